// File: rtl/mips_pkg.sv
// Shared datapath types for the register-file writeback path.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned CNT_W      = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // One writeback payload: destination register and the value to write.
    typedef struct packed {
        reg_addr_t         addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from a rotating pointer.
// The pointer moves past the winner only when the caller reports a transfer.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W-1:0] w_win;
    logic [N-1:0]     w_grant;
    logic             w_found;
    int unsigned      w_idx;

    // Scan p, p+1, .. mod N; first requesting index wins. Nothing is granted in reset.
    always_comb begin
        w_grant    = '0;
        w_win      = '0;
        w_found    = 1'b0;
        w_idx      = 0;
        w_ptr_next = r_ptr;
        for (int unsigned off = 0; off < N; off++) begin
            w_idx = 32'(r_ptr) + off;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!reset && !w_found && req[PTR_W'(w_idx)]) begin
                w_found                = 1'b1;
                w_grant[PTR_W'(w_idx)] = 1'b1;
                w_win                  = PTR_W'(w_idx);
            end
        end
        if (w_found) begin
            w_ptr_next = (32'(w_win) == N - 1) ? '0 : w_win + PTR_W'(1);
        end
    end

    // Pointer register: moves to winner+1 on an accepted transfer, else holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (advance && w_found) begin
            r_ptr <= w_ptr_next;
        end
    end

    assign grant = w_grant;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: arbitrates writeback requesters onto the
// single write-select decoder, registers the winner one cycle, filters writes to
// register 0, applies flush gating and counts committed writes.
module regfile_wb_arbiter #(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     flush,
    output logic [ADDR_W-1:0]        Sel,
    output logic                     wr_en,
    output logic [DATA_W-1:0]        wr_data,
    output logic [15:0]              grant_cnt
);

    import mips_pkg::*;

    localparam int unsigned PKG_DW = mips_pkg::DATA_W;

    logic [NREQ-1:0]   w_grant;
    logic              w_accept;
    logic              w_commit_next;
    logic              w_wr_en;
    wb_req_t           w_win;

    logic [ADDR_W-1:0] r_sel;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic [CNT_W-1:0]  r_grant_cnt;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (w_accept),
        .grant   (w_grant)
    );

    // Select the granted requester's payload (grant is one-hot or zero).
    always_comb begin
        w_win = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_win.addr = REG_ADDR_W'(req_addr[i*ADDR_W +: ADDR_W]);
                w_win.data = PKG_DW'(req_data[i*DATA_W +: DATA_W]);
            end
        end
    end

    // Accepted transfer commits next cycle unless it targets r0 or is flushed now.
    assign w_accept      = |(w_grant & req_valid);
    assign w_commit_next = w_accept && (w_win.addr != '0) && !flush;
    // Flush also drops the write currently presented to the decoder.
    assign w_wr_en       = r_wr_en && !flush;

    // Output stage: capture winner, cancel on reset, saturating commit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel       <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_grant_cnt <= '0;
        end else begin
            r_wr_en <= w_commit_next;
            if (w_accept) begin
                r_sel     <= ADDR_W'(w_win.addr);
                r_wr_data <= DATA_W'(w_win.data);
            end
            if (w_wr_en && (r_grant_cnt != {CNT_W{1'b1}})) begin
                r_grant_cnt <= r_grant_cnt + CNT_W'(1);
            end
        end
    end

    assign req_ready = w_grant;
    assign Sel       = r_sel;
    assign wr_en     = w_wr_en;
    assign wr_data   = r_wr_data;
    assign grant_cnt = 16'(r_grant_cnt);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, randomized run against a
// behavioural model, and a counter-saturation / mid-write reset sequence.
module tb_regfile_wb_arbiter;

    import mips_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 5;

    logic              clk;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              flush;
    logic [AW-1:0]     Sel;
    logic              wr_en;
    logic [DW-1:0]     wr_data;
    logic [15:0]       grant_cnt;

    regfile_wb_arbiter #(
        .NREQ   (NREQ),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .Sel       (Sel),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic [1:0] v, input reg_addr_t a0,
                         input reg_addr_t a1, input logic [31:0] d0, input logic [31:0] d1,
                         input logic fl);
        reset     = rst;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
        flush     = fl;
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  v;
        reg_addr_t   a0;
        reg_addr_t   a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        fl;
        logic [1:0]  rdy;
        logic [4:0]  sel;
        logic        wen;
        logic [31:0] data;
        logic [15:0] cnt;
    } vec_t;

    localparam logic [31:0] DA = 32'hAAAA_0003;
    localparam logic [31:0] DB = 32'hBBBB_0007;
    localparam logic [31:0] DC = 32'h0000_C00C;
    localparam logic [31:0] DD = 32'hD00D_0004;
    localparam logic [31:0] DE = 32'hDEAD_BEEF;

    vec_t tbl[17];

    // Behavioural model state for the random phase.
    int          m_ptr;
    logic [4:0]  m_sel;
    logic        m_wen;
    logic [31:0] m_data;
    int          m_cnt;
    wb_req_t     pend   [NREQ];
    logic        pend_v [NREQ];

    initial begin
        drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0);

        // Each row: inputs held for one cycle, and the outputs expected during it.
        //            rst  v      a0  a1  d0  d1     fl    rdy    sel wen  data  cnt
        tbl[0]  = '{1'b1, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b00, 0,  1'b0, 0,    0};
        tbl[1]  = '{1'b1, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b00, 0,  1'b0, 0,    0};
        tbl[2]  = '{1'b0, 2'b01, 9,  0,  DE, 0,     1'b0, 2'b01, 0,  1'b0, 0,    0};
        tbl[3]  = '{1'b0, 2'b00, 0,  0,  0,  0,     1'b0, 2'b00, 9,  1'b1, DE,   0};
        tbl[4]  = '{1'b0, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b10, 9,  1'b0, DE,   1};
        tbl[5]  = '{1'b0, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b01, 7,  1'b1, DB,   1};
        tbl[6]  = '{1'b0, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b10, 3,  1'b1, DA,   2};
        tbl[7]  = '{1'b0, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b01, 7,  1'b1, DB,   3};
        tbl[8]  = '{1'b0, 2'b10, 0,  0,  0,  1,     1'b0, 2'b10, 3,  1'b1, DA,   4};
        tbl[9]  = '{1'b0, 2'b00, 0,  0,  0,  0,     1'b0, 2'b00, 0,  1'b0, 1,    5};
        tbl[10] = '{1'b0, 2'b01, 12, 0,  DC, 0,     1'b1, 2'b01, 0,  1'b0, 1,    5};
        tbl[11] = '{1'b0, 2'b11, 12, 7,  DC, DB,    1'b0, 2'b10, 12, 1'b0, DC,   5};
        tbl[12] = '{1'b0, 2'b00, 0,  0,  0,  0,     1'b1, 2'b00, 7,  1'b0, DB,   5};
        tbl[13] = '{1'b0, 2'b00, 0,  0,  0,  0,     1'b0, 2'b00, 7,  1'b0, DB,   5};
        tbl[14] = '{1'b0, 2'b01, 4,  0,  DD, 0,     1'b0, 2'b01, 7,  1'b0, DB,   5};
        tbl[15] = '{1'b1, 2'b11, 3,  7,  DA, DB,    1'b0, 2'b00, 4,  1'b1, DD,   5};
        tbl[16] = '{1'b0, 2'b00, 0,  0,  0,  0,     1'b0, 2'b00, 0,  1'b0, 0,    0};

        @(posedge clk);
        #1;

        // Directed table.
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("vec%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d sel", i),   32'(Sel),       32'(tbl[i].sel));
            chk($sformatf("vec%0d wr_en", i), 32'(wr_en),     32'(tbl[i].wen));
            chk($sformatf("vec%0d data", i),  wr_data,        tbl[i].data);
            chk($sformatf("vec%0d cnt", i),   32'(grant_cnt), 32'(tbl[i].cnt));
            @(posedge clk);
            #1;
        end

        // Randomized run; requesters hold their request until it is accepted.
        for (int k = 0; k < NREQ; k++) begin
            pend_v[k] = 1'b0;
            pend[k]   = '0;
        end
        m_ptr = 0; m_sel = '0; m_wen = 1'b0; m_data = '0; m_cnt = 0;
        for (int k = 0; k < 1500; k++) begin
            logic       rst;
            logic       fl;
            int         win;
            logic [1:0] exp_rdy;
            logic       exp_wen;
            rst = (k == 0) || ($urandom_range(0, 31) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            for (int r = 0; r < NREQ; r++) begin
                if (!pend_v[r] && ($urandom_range(0, 1) == 1)) begin
                    pend_v[r]    = 1'b1;
                    pend[r].addr = ($urandom_range(0, 5) == 0) ? '0 : reg_addr_t'($urandom_range(1, 31));
                    pend[r].data = $urandom;
                end
            end
            drive(rst, {pend_v[1], pend_v[0]}, pend[0].addr, pend[1].addr,
                  pend[0].data, pend[1].data, fl);

            win = -1;
            if (!rst) begin
                for (int off = 0; off < NREQ; off++) begin
                    int idx;
                    idx = (m_ptr + off) % NREQ;
                    if (win < 0 && pend_v[idx]) win = idx;
                end
            end
            exp_rdy = (win >= 0) ? 2'(1 << win) : 2'b00;
            exp_wen = m_wen && !fl;

            @(negedge clk);
            chk("rand ready", 32'(req_ready), 32'(exp_rdy));
            chk("rand sel",   32'(Sel),       32'(m_sel));
            chk("rand wr_en", 32'(wr_en),     32'(exp_wen));
            chk("rand data",  wr_data,        m_data);
            chk("rand cnt",   32'(grant_cnt), 32'(m_cnt));

            if (rst) begin
                m_ptr = 0; m_sel = '0; m_wen = 1'b0; m_data = '0; m_cnt = 0;
            end else begin
                if (exp_wen && m_cnt < 65535) m_cnt++;
                if (win >= 0) begin
                    m_sel       = pend[win].addr;
                    m_data      = pend[win].data;
                    m_wen       = (pend[win].addr != 0) && !fl;
                    m_ptr       = (win + 1) % NREQ;
                    pend_v[win] = 1'b0;
                end else begin
                    m_wen = 1'b0;
                end
            end
            @(posedge clk);
            #1;
        end

        // Saturation of the commit counter, then reset in the middle of a write.
        drive(1'b1, 2'b00, '0, '0, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 5'd1, '0, 32'h1234_5678, '0, 1'b0);
        for (int k = 0; k < 65540; k++) begin
            @(posedge clk);
        end
        #1;
        @(negedge clk);
        chk("sat cnt", 32'(grant_cnt), 32'h0000_FFFF);
        chk("sat wr_en", 32'(wr_en), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
        end
        @(negedge clk);
        chk("sat hold cnt", 32'(grant_cnt), 32'h0000_FFFF);
        reset = 1'b1;
        #1;
        chk("rst ready", 32'(req_ready), 32'd0);
        chk("rst pending wr_en", 32'(wr_en), 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b00, '0, '0, '0, '0, 1'b0);
        @(negedge clk);
        chk("post rst wr_en", 32'(wr_en), 32'd0);
        chk("post rst cnt", 32'(grant_cnt), 32'd0);
        chk("post rst sel", 32'(Sel), 32'd0);
        chk("post rst data", wr_data, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
